// File: rtl/aes_enc_arbiter_pkg.sv
// Shared constants for the AES encryption-engine arbiter: block width, abort timeout, FSM encoding.
// Engine-side and requester-side datapaths all use AES_DW.
package aes_enc_arbiter_pkg;

    localparam int AES_DW      = 128;
    localparam int AES_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational grant, pointer flips on every accepted request.
// No backpressure of its own: the caller decides when a grant is consumed via advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;  // 0: requester 0 has priority on a tie

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~ptr;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Shares one AES engine between requesters A and B; response 2 + engine latency after acceptance, TIMEOUT + 2 on abort.
// One job in flight: requesters see ready only in IDLE, and DELIVER holds until the owner takes the result.
module aes_enc_arbiter
    import aes_enc_arbiter_pkg::*;
#(
    parameter int DW      = AES_DW,
    parameter int TIMEOUT = AES_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst1,
    input  logic          a_valid,
    input  logic [DW-1:0] a_text,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_text,
    output logic          b_ready,
    output logic          a_rsp_valid,
    input  logic          a_rsp_ready,
    output logic          b_rsp_valid,
    input  logic          b_rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          eng_start,
    output logic [DW-1:0] eng_text,
    output logic          eng_abort,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_data
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          owner;  // 0: A, 1: B
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          accept;
    logic          cnt_last;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst1),
        .req     ({b_valid, a_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign cnt_last = (cnt == CNT_LAST);
    assign accept   = a_ready || b_ready;

    always_comb begin
        state_nxt   = state;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        eng_start   = 1'b0;
        eng_abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gate with reset so ready stays low for the whole reset interval.
                a_ready = grant[0] && !rst1;
                b_ready = grant[1] && !rst1;
                if (a_ready || b_ready) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    state_nxt = ST_DELIVER;
                end else if (cnt_last) begin
                    eng_abort = 1'b1;
                    state_nxt = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                a_rsp_valid = !owner;
                b_rsp_valid = owner;
                if (owner ? b_rsp_ready : a_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst1) begin
        if (rst1) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            cnt      <= '0;
            eng_text <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner    <= b_ready;
                        eng_text <= b_ready ? b_text : a_text;
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    // A late eng_done beats the timeout in the same cycle.
                    if (eng_done) begin
                        rsp_data <= eng_data;
                        rsp_err  <= 1'b0;
                    end else if (cnt_last) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Bench for aes_enc_arbiter: schedule-level reference model checked every cycle plus directed literal checks.
module tb_aes_enc_arbiter;

    localparam int DW      = 128;
    localparam int TIMEOUT = 64;

    localparam logic [DW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] MASK = 128'ha5a55a5a_a5a55a5a_a5a55a5a_a5a55a5a;

    logic          clk;
    logic          rst1;
    logic          a_valid, b_valid;
    logic [DW-1:0] a_text, b_text;
    logic          a_ready, b_ready;
    logic          a_rsp_valid, b_rsp_valid;
    logic          a_rsp_ready, b_rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          eng_start;
    logic [DW-1:0] eng_text;
    logic          eng_abort;
    logic          eng_done;
    logic [DW-1:0] eng_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    aes_enc_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst1        (rst1),
        .a_valid     (a_valid),
        .a_text      (a_text),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_text      (b_text),
        .b_ready     (b_ready),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .eng_start   (eng_start),
        .eng_text    (eng_text),
        .eng_abort   (eng_abort),
        .eng_done    (eng_done),
        .eng_data    (eng_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: the FIPS-197 vector maps to its ciphertext, anything else is XOR-masked.
    function automatic logic [DW-1:0] aes_stub(input logic [DW-1:0] x);
        return (x == PT) ? CT : (x ^ MASK);
    endfunction

    task automatic chkd(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string n, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic chki(input string n, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Engine model: eng_lat cycles after eng_start it pulses eng_done; 0 means it never answers.
    int eng_lat   = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int start_cyc = 0;
    int abort_cyc = 0;

    initial begin : engine
        bit            pend;
        int            due;
        logic [DW-1:0] txt;
        pend     = 1'b0;
        due      = 0;
        txt      = '0;
        eng_done = 1'b0;
        eng_data = '0;
        forever begin
            @(negedge clk);
            if (rst1) begin
                pend = 1'b0;
            end else begin
                if (eng_abort) begin
                    pend = 1'b0;
                    abort_cnt++;
                    abort_cyc = cyc;
                end
                if (eng_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                    pend      = (eng_lat > 0);
                    due       = cyc + eng_lat;
                    txt       = eng_text;
                end
            end
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (pend && cyc == due) begin
                eng_done = 1'b1;
                eng_data = aes_stub(txt);
                pend     = 1'b0;
            end
        end
    end

    // Reference model: tracks one job by its acceptance cycle and predicts every output per cycle.
    bit            m_busy, m_have, m_owner, m_ptr;
    int            m_acc;
    logic [DW-1:0] m_text, m_exp;
    logic          m_err;
    bit            m_order[$];

    initial begin : model
        bit e_ga, e_gb;
        m_busy = 0; m_have = 0; m_owner = 0; m_ptr = 0; m_acc = 0;
        m_text = '0; m_exp = '0; m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst1) begin
                chkb("rst_a_ready", a_ready, 1'b0);
                chkb("rst_b_ready", b_ready, 1'b0);
                chkb("rst_a_rsp_valid", a_rsp_valid, 1'b0);
                chkb("rst_b_rsp_valid", b_rsp_valid, 1'b0);
                chkb("rst_eng_start", eng_start, 1'b0);
                chkb("rst_eng_abort", eng_abort, 1'b0);
                chkb("rst_rsp_err", rsp_err, 1'b0);
                chkd("rst_rsp_data", rsp_data, '0);
                chkd("rst_eng_text", eng_text, '0);
                m_busy = 0; m_have = 0; m_ptr = 0;
            end else begin
                e_ga = 0;
                e_gb = 0;
                if (!m_busy) begin
                    if (a_valid && b_valid) begin
                        e_ga = !m_ptr;
                        e_gb = m_ptr;
                    end else begin
                        e_ga = a_valid;
                        e_gb = b_valid;
                    end
                end
                chkb("a_ready", a_ready, e_ga);
                chkb("b_ready", b_ready, e_gb);
                chkb("eng_start", eng_start, m_busy && cyc == m_acc + 1);
                chkb("eng_abort", eng_abort,
                     m_busy && !m_have && cyc == m_acc + TIMEOUT + 1 && !eng_done);
                if (m_busy) chkd("eng_text", eng_text, m_text);
                chkb("a_rsp_valid", a_rsp_valid, m_have && !m_owner);
                chkb("b_rsp_valid", b_rsp_valid, m_have && m_owner);
                if (m_have) begin
                    chkd("rsp_data", rsp_data, m_exp);
                    chkb("rsp_err", rsp_err, m_err);
                end

                if (m_have) begin
                    if (m_owner ? b_rsp_ready : a_rsp_ready) begin
                        m_busy = 0;
                        m_have = 0;
                    end
                end else if (m_busy) begin
                    if (eng_done && cyc >= m_acc + 2) begin
                        m_have = 1; m_exp = aes_stub(m_text); m_err = 1'b0;
                    end else if (cyc == m_acc + TIMEOUT + 1) begin
                        m_have = 1; m_exp = '0; m_err = 1'b1;
                    end
                end
                if (e_ga || e_gb) begin
                    m_busy  = 1;
                    m_owner = e_gb;
                    m_text  = e_gb ? b_text : a_text;
                    m_acc   = cyc;
                    m_ptr   = !m_ptr;
                    m_order.push_back(e_gb);
                end
            end
        end
    end

    task automatic send(input bit is_b, input logic [DW-1:0] t, output int acc);
        bit ok = 0;
        acc = 0;
        if (is_b) begin b_valid = 1'b1; b_text = t; end
        else      begin a_valid = 1'b1; a_text = t; end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_b ? b_ready : a_ready) begin
                ok  = 1;
                acc = cyc;
                break;
            end
        end
        chkb("send_accepted", ok, 1'b1);
        @(posedge clk);
        #1;
        if (is_b) b_valid = 1'b0;
        else      a_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit is_b, output int c, output logic [DW-1:0] d, output logic e);
        bit ok = 0;
        c = 0; d = '0; e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_b ? b_rsp_valid : a_rsp_valid) begin
                ok = 1; c = cyc; d = rsp_data; e = rsp_err;
                break;
            end
        end
        chkb("rsp_arrived", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int            acc, acc_a, acc_b, rc, rel, s0, a0;
        logic [DW-1:0] d;
        logic          e;
        bit            exp_ord [8];
        exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};

        rst1 = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_text = '0; b_text = '0;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;

        // Single request, presented while still in reset; accepted in the first cycle out of it.
        a_valid = 1'b1; a_text = PT; eng_lat = 11;
        repeat (3) @(posedge clk);
        #1;
        s0 = start_cnt;
        rst1 = 1'b0;
        rel = cyc;
        send(0, PT, acc);
        chki("first_accept_cycle", acc, rel);
        wait_rsp(0, rc, d, e);
        chki("single_latency", rc - acc, 13);
        chkd("single_data", d, CT);
        chkb("single_err", e, 1'b0);
        chki("single_start_count", start_cnt - s0, 1);

        // Timeout abort, then a normal job from B.
        eng_lat = 0;
        send(0, 128'h0123, acc);
        wait_rsp(0, rc, d, e);
        chki("abort_after_start", abort_cyc - start_cyc, TIMEOUT);
        chki("timeout_latency", rc - acc, TIMEOUT + 2);
        chkd("timeout_data", d, '0);
        chkb("timeout_err", e, 1'b1);
        eng_lat = 3;
        send(1, 128'h0, acc);
        wait_rsp(1, rc, d, e);
        chki("post_timeout_latency", rc - acc, 5);
        chkd("post_timeout_data", d, 128'ha5a55a5a_a5a55a5a_a5a55a5a_a5a55a5a);
        chkb("post_timeout_err", e, 1'b0);

        // Response backpressure with B waiting.
        a_rsp_ready = 1'b0;
        eng_lat = 5;
        send(0, 128'h1, acc);
        b_valid = 1'b1;
        b_text  = '1;
        wait_rsp(0, rc, d, e);
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chkd("stall_data", rsp_data, 128'ha5a55a5a_a5a55a5a_a5a55a5a_a5a55a5b);
            chkb("stall_b_ready", b_ready, 1'b0);
            chkb("stall_a_rsp_valid", a_rsp_valid, 1'b1);
        end
        chki("stall_start_count", start_cnt - s0, 0);
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b1;
        send(1, '1, acc);
        wait_rsp(1, rc, d, e);
        chkd("after_stall_data", d, 128'h5a5aa5a5_5a5aa5a5_5a5aa5a5_5a5aa5a5);

        // Reset while the engine is busy.
        eng_lat = 40;
        send(0, 128'hdeadbeef_00000000_cafef00d_12345678, acc);
        repeat (5) @(posedge clk);
        #1;
        a0 = abort_cnt;
        rst1 = 1'b1;
        #1;
        chkd("async_rst_eng_text", eng_text, '0);
        chkd("async_rst_rsp_data", rsp_data, '0);
        chkb("async_rst_a_rsp_valid", a_rsp_valid, 1'b0);
        chkb("async_rst_eng_start", eng_start, 1'b0);
        chkb("async_rst_rsp_err", rsp_err, 1'b0);

        // Contention straight out of reset: pointer starts at A.
        m_order.delete();
        eng_lat = 2;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        fork
            for (int i = 0; i < 4; i++) send(0, {96'h0, 32'ha000 + 32'(i)}, acc_a);
            for (int j = 0; j < 4; j++) send(1, {96'h0, 32'hb000 + 32'(j)}, acc_b);
        join
        repeat (10) @(posedge clk);
        #1;
        chki("rst_no_abort", abort_cnt - a0, 0);
        chki("order_len", m_order.size(), 8);
        for (int k = 0; k < 8 && k < m_order.size(); k++) begin
            chkb("grant_order", m_order[k], exp_ord[k]);
        end

        // eng_done lands exactly in the timeout cycle.
        eng_lat = TIMEOUT;
        a0 = abort_cnt;
        send(0, 128'h5, acc);
        wait_rsp(0, rc, d, e);
        chki("coincident_latency", rc - acc, TIMEOUT + 2);
        chkd("coincident_data", d, 128'ha5a55a5a_a5a55a5a_a5a55a5a_a5a55a5f);
        chkb("coincident_err", e, 1'b0);
        chki("coincident_no_abort", abort_cnt - a0, 0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
